with_ssi: RTL and testbench

WITH_SSI -- requirements
Module: with_ssi

---
 rtl/with_ssi_if.sv | 37 +++
 rtl/with_ssi.sv | 64 ++++++
 tb/tb_with_ssi.sv | 137 +++++++++++++
 3 files changed

// File: rtl/with_ssi_if.sv
// Operand/result bundle for with_ssi: 2x2-bit operands in, 4-bit registered product out.
// chk_err exists only when WITH_SSI_SELFCHECK_EN is defined.
interface with_ssi_if;
   logic in_valid;
   logic a;
   logic b;
   logic c;
   logic d;
   logic out_valid;
   logic f0;
   logic f1;
   logic f2;
   logic f3;
`ifdef WITH_SSI_SELFCHECK_EN
   logic chk_err;

   modport master (
      output in_valid, a, b, c, d,
      input  out_valid, f0, f1, f2, f3, chk_err
   );

   modport slave (
      input  in_valid, a, b, c, d,
      output out_valid, f0, f1, f2, f3, chk_err
   );
`else
   modport master (
      output in_valid, a, b, c, d,
      input  out_valid, f0, f1, f2, f3
   );

   modport slave (
      input  in_valid, a, b, c, d,
      output out_valid, f0, f1, f2, f3
   );
`endif
endinterface : with_ssi_if

// File: rtl/with_ssi.sv
// Registered 2x2-bit unsigned multiplier built from SSI gate equations, 1-cycle latency.
// Optional sticky self-check against X*Y is enabled by defining WITH_SSI_SELFCHECK_EN.
module with_ssi (
   input  logic       clk,
   input  logic       rst,
   with_ssi_if.slave  bus
);

   logic [3:0] p_gate;
   logic [3:0] p_q;
   logic       valid_q;

   // Pure gate-level product; f2 suppresses the 3*3 case where the MSB pair overflows into f3.
   always_comb begin
      p_gate[0] = bus.b & bus.d;
      p_gate[1] = (bus.a & bus.d) ^ (bus.b & bus.c);
      p_gate[2] = (bus.a & bus.c) & ~(bus.b & bus.d);
      p_gate[3] = bus.a & bus.b & bus.c & bus.d;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         p_q     <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            p_q <= p_gate;
         end
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.f0        = p_q[0];
   assign bus.f1        = p_q[1];
   assign bus.f2        = p_q[2];
   assign bus.f3        = p_q[3];

`ifdef WITH_SSI_SELFCHECK_EN
   logic [3:0] x_ext;
   logic [3:0] y_ext;
   logic [3:0] p_ref;
   logic       chk_err_q;

   always_comb begin
      x_ext = {2'b00, bus.a, bus.b};
      y_ext = {2'b00, bus.c, bus.d};
      p_ref = x_ext * y_ext;
   end

   // Sticky: sets on the same edge the mismatching product registers, clears only on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         chk_err_q <= 1'b0;
      end else if (bus.in_valid && (p_gate != p_ref)) begin
         chk_err_q <= 1'b1;
      end
   end

   assign bus.chk_err = chk_err_q;
`endif

endmodule : with_ssi

// File: tb/tb_with_ssi.sv
// Self-checking bench for with_ssi: directed vector table, a mid-stream reset sequence,
// and randomized traffic against a behavioural product model.
module tb_with_ssi;

   logic clk = 1'b0;
   logic rst;

   with_ssi_if bus ();

   with_ssi dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       in_valid;
      logic [3:0] abcd;
      logic [3:0] exp_f;
      logic       exp_v;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Behavioural model: registered X*Y with hold and reset.
   int   m_f = 0;
   int   m_v = 0;

   function automatic vec_t mk(logic r, logic v, logic [3:0] in, logic [3:0] f, logic ov);
      vec_t t;
      t.rst      = r;
      t.in_valid = v;
      t.abcd     = in;
      t.exp_f    = f;
      t.exp_v    = ov;
      return t;
   endfunction

   task automatic check(string name, logic [7:0] act, logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, advance past the edge, and update the model.
   task automatic apply(logic r, logic v, logic [3:0] in);
      rst          = r;
      bus.in_valid = v;
      {bus.a, bus.b, bus.c, bus.d} = in;
      @(posedge clk);
      #1;
      if (r) begin
         m_f = 0;
         m_v = 0;
      end else begin
         m_v = v ? 1 : 0;
         if (v) m_f = int'(in[3:2]) * int'(in[1:0]);
      end
   endtask

   function automatic logic [3:0] dut_f();
      return {bus.f3, bus.f2, bus.f1, bus.f0};
   endfunction

   task automatic check_err(string name);
`ifdef WITH_SSI_SELFCHECK_EN
      check(name, {7'd0, bus.chk_err}, 8'd0);
`endif
   endtask

   initial begin
      int prod_tbl[16] = '{0, 0, 0, 0, 0, 1, 2, 3, 0, 2, 4, 6, 0, 3, 6, 9};

      rst          = 1'b1;
      bus.in_valid = 1'b0;
      {bus.a, bus.b, bus.c, bus.d} = 4'b0000;

      // Reset held with valid all-ones operands.
      vecs.push_back(mk(1'b1, 1'b1, 4'b1111, 4'd0, 1'b0));
      vecs.push_back(mk(1'b1, 1'b1, 4'b1111, 4'd0, 1'b0));
      // Exhaustive back-to-back sweep.
      for (int i = 0; i < 16; i++) begin
         vecs.push_back(mk(1'b0, 1'b1, 4'(i), 4'(prod_tbl[i]), 1'b1));
      end
      // Hold: capture 9, then ignore operands while in_valid is low.
      vecs.push_back(mk(1'b0, 1'b1, 4'b1111, 4'd9, 1'b1));
      for (int i = 0; i < 3; i++) begin
         vecs.push_back(mk(1'b0, 1'b0, 4'b0110, 4'd9, 1'b0));
      end
      // Reset beats a simultaneous capture; next capture proceeds normally.
      vecs.push_back(mk(1'b1, 1'b1, 4'b1010, 4'd0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 4'b1011, 4'd6, 1'b1));
      vecs.push_back(mk(1'b0, 1'b0, 4'b1111, 4'd6, 1'b0));

      foreach (vecs[i]) begin
         apply(vecs[i].rst, vecs[i].in_valid, vecs[i].abcd);
         check($sformatf("vec%0d_f", i), {4'd0, dut_f()}, {4'd0, vecs[i].exp_f});
         check($sformatf("vec%0d_v", i), {7'd0, bus.out_valid}, {7'd0, vecs[i].exp_v});
         check_err($sformatf("vec%0d_err", i));
      end

      // Mid-stream reset discards the pending result; first capture afterwards is normal.
      apply(1'b0, 1'b1, 4'b1111);
      check("mid_pre_f", {4'd0, dut_f()}, 8'd9);
      apply(1'b1, 1'b0, 4'b0101);
      check("mid_rst_f", {4'd0, dut_f()}, 8'd0);
      check("mid_rst_v", {7'd0, bus.out_valid}, 8'd0);
      apply(1'b0, 1'b1, 4'b0101);
      check("mid_post_f", {4'd0, dut_f()}, 8'd1);
      check("mid_post_v", {7'd0, bus.out_valid}, 8'd1);

      // Randomized traffic against the model.
      for (int i = 0; i < 300; i++) begin
         logic       r;
         logic       v;
         logic [3:0] in;
         r  = ($urandom_range(0, 19) == 0);
         v  = $urandom_range(0, 2) != 0;
         in = 4'($urandom_range(0, 15));
         apply(r, v, in);
         check($sformatf("rnd%0d_f", i), {4'd0, dut_f()}, 8'(m_f));
         check($sformatf("rnd%0d_v", i), {7'd0, bus.out_valid}, 8'(m_v));
         check_err($sformatf("rnd%0d_err", i));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_with_ssi
